spi_slave_param: RTL and testbench

Parametrised SPI slave for the FPGA side of the group project's master/slave link. It replaces the fixed 4-bit, receive-only slave with a full-duplex one. It has configurable word width, SPI mode (CPOL/CPHA) and bit order, and supports back-to-back words within a single `ss_n` frame. The block oversamples the SPI pins on the system clock; received words and transmit data cross to the user logic via a valid pulse and a valid/ready handshake.

---
 rtl/spi_slave_param.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// spi_slave_param: full-duplex SPI slave that oversamples the pins on clk.
// The word width, CPOL/CPHA mode and bit order are set by parameters.
// Back-to-back words are allowed inside one ss_n frame.
//
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   ss_n, sck, mosi    SPI pins, asynchronous to clk
//   miso               slave data out, 0 while not selected
//   rx_data/rx_valid   last received word, with a one-cycle pulse on update
//   tx_data/tx_valid   next word to send; accepted when tx_ready is high
//   tx_ready           the one-entry holding register is empty
//   busy               a frame is active
//   frame_err          pulse: ss_n rose in the middle of a word
//   tx_underrun        pulse: a word load found the holding register empty
module spi_slave_param #(
  parameter int DATA_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_underrun
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;
  state_t state, state_nxt;

  // [1] is the synced level and [2] is the previous level.
  // mosi has the same depth, so the bit used at an sck edge was set up
  // well before that edge reached the pin.
  logic [2:0]        ss_s, sck_s, mosi_s;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, hold, rx_next;
  logic              hold_full;
  // Set at a word boundary. The next shift edge then does the deferred
  // load (CPHA=0) or is skipped (CPHA=1), and the flag clears.
  logic              hold_edge;

  logic ss_hi, ss_fall, sck_lead, sck_trail, sample_edge, shift_edge;
  logic last_bit, accept;
  logic do_load, do_shift, do_sample, set_hold, clr_hold, abort;

  assign ss_hi       = ss_s[1];
  assign ss_fall     = ~ss_s[1] & ss_s[2];
  assign sck_lead    = (sck_s[1] != 1'(CPOL)) && (sck_s[2] == 1'(CPOL));
  assign sck_trail   = (sck_s[1] == 1'(CPOL)) && (sck_s[2] != 1'(CPOL));
  assign sample_edge = (CPHA == 0) ? sck_lead  : sck_trail;
  assign shift_edge  = (CPHA == 0) ? sck_trail : sck_lead;
  assign last_bit    = (cnt == CNT_W'(DATA_W - 1));
  assign rx_next     = (LSB_FIRST != 0) ? {mosi_s[2], rx_sr[DATA_W-1:1]}
                                        : {rx_sr[DATA_W-2:0], mosi_s[2]};
  assign accept      = tx_valid & ~hold_full;

  assign tx_ready = ~hold_full;
  assign busy     = (state != IDLE);
  assign miso     = (state == XFER) &
                    ((LSB_FIRST != 0) ? tx_sr[0] : tx_sr[DATA_W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A high ss_n is checked before any sck edge, so a rising ss_n wins
  // when both happen in the same cycle.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_sample = 1'b0;
    set_hold  = 1'b0;
    clr_hold  = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: if (ss_fall) state_nxt = LOAD;
      LOAD: begin
        if (ss_hi) state_nxt = IDLE;
        else begin
          do_load   = 1'b1;
          set_hold  = (CPHA != 0);
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (ss_hi) begin
          state_nxt = IDLE;
          abort     = (cnt != '0);
        end else if (sample_edge) begin
          do_sample = 1'b1;
          if (last_bit) begin
            set_hold = 1'b1;
            if (CPHA != 0) do_load = 1'b1;
          end
        end else if (shift_edge) begin
          clr_hold = 1'b1;
          if (!hold_edge)     do_shift = 1'b1;
          else if (CPHA == 0) do_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_s        <= '0;
      sck_s       <= '0;
      mosi_s      <= '0;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      hold_edge   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      ss_s        <= {ss_s[1:0], ss_n};
      sck_s       <= {sck_s[1:0], sck};
      mosi_s      <= {mosi_s[1:0], mosi};
      rx_valid    <= 1'b0;
      frame_err   <= abort;
      tx_underrun <= 1'b0;

      // A partial word is dropped on abort. rx_data only changes when a
      // word completes.
      if (state == IDLE || abort) begin
        cnt <= '0;
      end else if (do_sample) begin
        rx_sr <= rx_next;
        if (last_bit) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      if (state_nxt == IDLE) hold_edge <= 1'b0;
      else if (set_hold)     hold_edge <= 1'b1;
      else if (clr_hold)     hold_edge <= 1'b0;

      if (do_load) begin
        if (hold_full) tx_sr <= hold;
        else begin
          tx_sr       <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_sr <= (LSB_FIRST != 0) ? (tx_sr >> 1) : (tx_sr << 1);
      end

      // A load in the same cycle as an accept has already read the old
      // (empty) contents, so the new word stays held.
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (do_load) begin
        hold_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param. It uses a mode-0 MSB-first instance
// and a mode-3 LSB-first instance. The two share sck/mosi/tx_data and have
// separate selects.
module tb_spi_slave_param;
  localparam int H = 5;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n, ss0_n, ss3_n, sck, mosi, tx_valid0, tx_valid3;
  logic [7:0] tx_data;
  logic       miso0, rx_valid0, tx_ready0, busy0, frame_err0, tx_underrun0;
  logic       miso3, rx_valid3, tx_ready3, busy3, frame_err3, tx_underrun3;
  logic [7:0] rx_data0, rx_data3;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss0_n), .sck(sck), .mosi(mosi),
    .miso(miso0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_data(tx_data), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .busy(busy0), .frame_err(frame_err0), .tx_underrun(tx_underrun0));

  spi_slave_param #(.DATA_W(8), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u3 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss3_n), .sck(sck), .mosi(mosi),
    .miso(miso3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .tx_data(tx_data), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .busy(busy3), .frame_err(frame_err3), .tx_underrun(tx_underrun3));

  int vectors = 0, miscompares = 0;
  int rv0 = 0, rv3 = 0, fe0 = 0, ur0 = 0, ur3 = 0;
  logic [7:0] hist0 [8];

  // Pulse monitors. They count cycles high, so a stretched pulse shows up
  // as an extra count.
  always @(negedge clk) begin
    if (rx_valid0) begin hist0[rv0[2:0]] = rx_data0; rv0++; end
    if (rx_valid3) rv3++;
    if (frame_err0) fe0++;
    if (tx_underrun0) ur0++;
    if (tx_underrun3) ur3++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int d, input logic [7:0] v);
    tx_data = v;
    if (d == 0) tx_valid0 = 1'b1; else tx_valid3 = 1'b1;
    cyc(1);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
  endtask

  task automatic frame_begin(input int d);
    if (d == 0) ss0_n = 1'b0; else ss3_n = 1'b0;
    cyc(8);
  endtask

  task automatic frame_end(input int d);
    cyc(6);
    if (d == 0) ss0_n = 1'b1; else ss3_n = 1'b1;
    cyc(8);
  endtask

  // Master side: d==0 is mode 0 MSB first, d==3 is mode 3 LSB first.
  task automatic xfer(input int d, input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi);
    logic pol, pha, lsb;
    pol = (d == 3); pha = (d == 3); lsb = (d == 3);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : 7 - i;
      if (!pha) begin
        mosi = mo[idx];
        cyc(H);
        mi[idx] = (d == 3) ? miso3 : miso0;
        sck = ~pol;
        cyc(H);
        sck = pol;
      end else begin
        sck  = ~pol;
        mosi = mo[idx];
        cyc(H);
        mi[idx] = (d == 3) ? miso3 : miso0;
        sck = pol;
        cyc(H);
      end
    end
  endtask

  initial begin
    logic [7:0] mi;
    int base;
    rst_n = 1'b0; ss0_n = 1'b1; ss3_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = '0; tx_valid0 = 1'b0; tx_valid3 = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_miso", miso0, 0);
    chk("rst_rx_data", rx_data0, 8'h00);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_tx_ready", tx_ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_frame_err", frame_err0, 0);
    chk("rst_underrun", tx_underrun0, 0);
    chk("rst_tx_ready3", tx_ready3, 1);

    // Mode 0, a single word.
    push(0, 8'h3C);
    chk("m0_hold_full", tx_ready0, 0);
    frame_begin(0);
    chk("m0_busy", busy0, 1);
    chk("m0_no_underrun", ur0, 0);
    xfer(0, 8'hA5, 8, mi);
    frame_end(0);
    chk("m0_rx_data", rx_data0, 8'hA5);
    chk("m0_rx_pulses", rv0, 1);
    chk("m0_miso_word", mi, 8'h3C);
    chk("m0_idle_busy", busy0, 0);

    // Two words in one frame; the second tx word is written mid-word-1.
    push(0, 8'h11);
    frame_begin(0);
    fork
      xfer(0, 8'hDE, 8, mi);
      begin cyc(20); push(0, 8'h22); end
    join
    chk("w2_miso_1", mi, 8'h11);
    xfer(0, 8'hAD, 8, mi);
    chk("w2_miso_2", mi, 8'h22);
    frame_end(0);
    chk("w2_rx_pulses", rv0, 3);
    chk("w2_rx_1", hist0[1], 8'hDE);
    chk("w2_rx_2", hist0[2], 8'hAD);
    chk("w2_tx_ready", tx_ready0, 1);

    // Underrun: nothing held at LOAD.
    base = ur0;
    frame_begin(0);
    chk("ur_pulse", ur0 - base, 1);
    xfer(0, 8'h33, 8, mi);
    chk("ur_miso_zero", mi, 8'h00);
    frame_end(0);
    chk("ur_rx_data", rx_data0, 8'h33);

    // Abort after 5 bits.
    base = rv0;
    frame_begin(0);
    xfer(0, 8'hF0, 5, mi);
    frame_end(0);
    chk("ab_frame_err", fe0, 1);
    chk("ab_rx_kept", rx_data0, 8'h33);
    chk("ab_no_valid", rv0 - base, 0);
    chk("ab_busy", busy0, 0);
    frame_begin(0);
    xfer(0, 8'h5A, 8, mi);
    frame_end(0);
    chk("ab_next_rx", rx_data0, 8'h5A);

    // Reset pulse after 3 bits.
    frame_begin(0);
    xfer(0, 8'hFF, 3, mi);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("mr_rx_data", rx_data0, 8'h00);
    chk("mr_busy", busy0, 0);
    chk("mr_tx_ready", tx_ready0, 1);
    chk("mr_miso", miso0, 0);
    chk("mr_rx_valid", rx_valid0, 0);
    ss0_n = 1'b1;
    cyc(8);
    push(0, 8'h96);
    frame_begin(0);
    xfer(0, 8'hC3, 8, mi);
    frame_end(0);
    chk("mr_next_rx", rx_data0, 8'hC3);
    chk("mr_next_miso", mi, 8'h96);
    chk("mr_no_frame_err", fe0, 1);

    // Mode 3, LSB first.
    sck = 1'b1;
    cyc(8);
    push(3, 8'h7E);
    frame_begin(3);
    chk("m3_busy", busy3, 1);
    chk("m3_no_underrun", ur3, 0);
    xfer(3, 8'h81, 8, mi);
    frame_end(3);
    chk("m3_rx_data", rx_data3, 8'h81);
    chk("m3_miso_word", mi, 8'h7E);
    chk("m3_rx_pulses", rv3, 1);
    chk("m3_frame_err", frame_err3, 0);
    chk("m3_idle_busy", busy3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
